// File: rtl/ps2_key_fifo.sv
// PS/2 device-to-host receiver: synchroniser, clock filter, frame FSM with timeout,
// E0/E1/F0 prefix folding and a first-word fall-through event FIFO.
module ps2_key_fifo #(
    parameter int unsigned HI_LEN       = 4,
    parameter int unsigned LO_LEN       = 12,
    parameter int unsigned TIMEOUT_BITS = 16,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned PARITY_CHECK = 1,
    localparam int unsigned AW          = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    output logic [10:0]   evt_data,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [AW:0]   evt_count,
    output logic          parity_err,
    output logic          frame_err,
    output logic          overflow
);

    localparam int unsigned HL = HI_LEN + LO_LEN;
    localparam int unsigned CW = AW + 1;
    localparam logic [HL-1:0] EdgePat = {{HI_LEN{1'b1}}, {LO_LEN{1'b0}}};
    localparam logic [TIMEOUT_BITS-1:0] TmoOne = 1;
    localparam logic [TIMEOUT_BITS-1:0] TmoMax = '1;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [1:0]              clk_sync_q, clk_sync_d;
    logic [1:0]              dat_sync_q, dat_sync_d;
    logic [HL-1:0]           hist_q, hist_d;
    state_e                  state_q, state_d;
    logic [2:0]              bitcnt_q, bitcnt_d;
    logic [7:0]              byte_q, byte_d;
    logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
    logic                    ext_q, ext_d, rel_q, rel_d, e1_q, e1_d;
    logic                    emit_q, emit_d;
    logic [10:0]             emit_data_q, emit_data_d;
    logic                    parity_err_q, parity_err_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overflow_q, overflow_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]             count_q, count_d;
    logic [10:0]             mem_q [FIFO_DEPTH];

    logic edge_det, data_s, pop, full, push_ok;

    assign data_s   = dat_sync_q[1];
    assign edge_det = (hist_q == EdgePat);

    // Synchroniser and falling-edge filter; newest sample enters at the LSB.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        hist_d     = {hist_q[HL-2:0], clk_sync_q[1]};
    end

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        byte_d       = byte_q;
        ext_d        = ext_q;
        rel_d        = rel_q;
        e1_d         = e1_q;
        emit_d       = 1'b0;
        emit_data_d  = emit_data_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        tmo_d        = tmo_q;

        if (edge_det) begin
            tmo_d = '0;
        end else if (tmo_q != TmoMax) begin
            tmo_d = tmo_q + TmoOne;
        end

        if (edge_det) begin
            unique case (state_q)
                StIdle: begin
                    if (!data_s) begin
                        state_d  = StData;
                        bitcnt_d = 3'd0;
                    end
                end
                StData: begin
                    byte_d   = {data_s, byte_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    if ((data_s ^ (^byte_q)) || (PARITY_CHECK == 0)) begin
                        state_d = StStop;
                    end else begin
                        state_d      = StIdle;
                        parity_err_d = 1'b1;
                        ext_d        = 1'b0;
                        rel_d        = 1'b0;
                        e1_d         = 1'b0;
                    end
                end
                StStop: begin
                    state_d = StIdle;
                    if (!data_s) begin
                        frame_err_d = 1'b1;
                    end else begin
                        unique case (byte_q)
                            8'hE0:   ext_d = 1'b1;
                            8'hF0:   rel_d = 1'b1;
                            8'hE1:   e1_d  = 1'b1;
                            default: begin
                                emit_d      = 1'b1;
                                emit_data_d = {e1_q, rel_q, ext_q, byte_q};
                                ext_d       = 1'b0;
                                rel_d       = 1'b0;
                                e1_d        = 1'b0;
                            end
                        endcase
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (tmo_q == TmoMax && state_q != StIdle) begin
            // Stalled mid-frame: abandon the frame but keep any prefixes already seen.
            state_d     = StIdle;
            frame_err_d = 1'b1;
        end
    end

    assign evt_valid = (count_q != '0);
    assign pop       = evt_valid && evt_ready;
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign push_ok   = emit_q && (!full || pop);

    always_comb begin
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CW'(push_ok) - CW'(pop);
        overflow_d = overflow_q | (emit_q && full && !pop);
    end

    assign evt_data   = evt_valid ? mem_q[rd_ptr_q] : 11'd0;
    assign evt_count  = count_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q   <= 2'b11;
            dat_sync_q   <= 2'b11;
            hist_q       <= '1;
            state_q      <= StIdle;
            bitcnt_q     <= 3'd0;
            byte_q       <= 8'd0;
            tmo_q        <= '0;
            ext_q        <= 1'b0;
            rel_q        <= 1'b0;
            e1_q         <= 1'b0;
            emit_q       <= 1'b0;
            emit_data_q  <= 11'd0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            hist_q       <= hist_d;
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            byte_q       <= byte_d;
            tmo_q        <= tmo_d;
            ext_q        <= ext_d;
            rel_q        <= rel_d;
            e1_q         <= e1_d;
            emit_q       <= emit_d;
            emit_data_q  <= emit_data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: the head is only exposed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= emit_data_q;
        end
    end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo: frames are bit-banged on ps2_clk/ps2_data and
// expected events are queued, then checked as the DUT hands them out.
module tb_ps2_key_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] evt_data;
    logic        evt_valid;
    logic        evt_ready = 1'b1;
    logic [3:0]  evt_count;
    logic        parity_err, frame_err, overflow;

    int n_cmp = 0;
    int n_err = 0;
    int n_par = 0;
    int n_frm = 0;
    int n_vld = 0;
    logic [10:0] exp_q[$];
    logic [10:0] exp_v;

    ps2_key_fifo #(
        .HI_LEN(4), .LO_LEN(12), .TIMEOUT_BITS(10), .FIFO_DEPTH(8), .PARITY_CHECK(1)
    ) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_count(evt_count), .parity_err(parity_err), .frame_err(frame_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic bad_par);
        return {1'b1, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    // Sends the first n bits of a frame, LSB first; bit glitch_at gets a 6-cycle low glitch.
    task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_at);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            if (i == glitch_at) begin
                ps2_clk = 1'b1; cyc(7);
                ps2_clk = 1'b0; cyc(6);
                ps2_clk = 1'b1; cyc(7);
            end else begin
                ps2_clk = 1'b1; cyc(20);
            end
            ps2_clk = 1'b0; cyc(20);
        end
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        cyc(20);
    endtask

    task automatic send(input logic [7:0] d, input logic bad_par);
        send_bits(frame(d, bad_par), 11, -1);
    endtask

    // Scoreboard: every handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL evt_unexpected: got %0h want none", evt_data);
            end
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                n_cmp++;
                assert (evt_data === exp_v) else begin
                    n_err++;
                    $error("FAIL evt_data: got %0h want %0h", evt_data, exp_v);
                end
            end
        end
        if (parity_err || frame_err) begin
            n_cmp++;
            assert (!(parity_err && frame_err)) else begin
                n_err++;
                $error("FAIL err_exclusive: got both want one");
            end
        end
        if (parity_err) n_par++;
        if (frame_err) n_frm++;
        if (evt_valid) n_vld++;
    end

    initial begin
        int p0, f0, v0;

        cyc(4);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_count", 32'(evt_count), 0);
        chk("rst_data", 32'(evt_data), 0);
        chk("rst_errs", 32'({parity_err, frame_err, overflow}), 0);
        reset = 1'b0;
        cyc(10);

        // 1: single plain key
        v0 = n_vld;
        exp_q.push_back(11'h01C);
        send(8'h1C, 1'b0);
        cyc(40);
        chk("t1_drained", 32'(exp_q.size()), 0);
        chk("t1_valid_cycles", 32'(n_vld - v0), 1);
        chk("t1_count", 32'(evt_count), 0);

        // 2: prefixes fold into one event, then clear
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        exp_q.push_back(11'h374);
        send(8'h74, 1'b0);
        exp_q.push_back(11'h01C);
        send(8'h1C, 1'b0);
        cyc(40);
        chk("t2_drained", 32'(exp_q.size()), 0);

        // 3: parity error drops the byte and the pending prefix
        p0 = n_par;
        f0 = n_frm;
        send(8'hE0, 1'b0);
        send(8'h1C, 1'b1);
        cyc(10);
        chk("t3_parity_pulse", 32'(n_par - p0), 1);
        chk("t3_no_frame_err", 32'(n_frm - f0), 0);
        chk("t3_no_event", 32'(evt_count), 0);
        exp_q.push_back(11'h01B);
        send(8'h1B, 1'b0);
        cyc(40);
        chk("t3_drained", 32'(exp_q.size()), 0);

        // 4: overflow with consumer stalled
        evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(11'(8'h10 + i));
            send(8'(8'h10 + i), 1'b0);
        end
        cyc(10);
        chk("t4_count_full", 32'(evt_count), 8);
        chk("t4_overflow", 32'(overflow), 1);
        chk("t4_head", 32'(evt_data), 32'h010);
        evt_ready = 1'b1;
        cyc(20);
        chk("t4_drained", 32'(exp_q.size()), 0);
        chk("t4_count_empty", 32'(evt_count), 0);

        // 5: timeout mid-frame
        f0 = n_frm;
        send_bits(frame(8'h55, 1'b0), 6, -1);
        cyc(900);
        chk("t5_no_early_timeout", 32'(n_frm - f0), 0);
        cyc(200);
        chk("t5_timeout_pulse", 32'(n_frm - f0), 1);
        exp_q.push_back(11'h02A);
        send(8'h2A, 1'b0);
        cyc(40);
        chk("t5_drained", 32'(exp_q.size()), 0);

        // 6: glitch rejection, then reset mid-frame
        exp_q.push_back(11'h033);
        send_bits(frame(8'h33, 1'b0), 11, 4);
        cyc(40);
        chk("t6_glitch_drained", 32'(exp_q.size()), 0);
        chk("t6_overflow_sticky", 32'(overflow), 1);
        send_bits(frame(8'h44, 1'b0), 4, -1);
        reset = 1'b1;
        cyc(2);
        chk("t6_rst_outputs",
            32'({evt_valid, evt_count, evt_data, parity_err, frame_err, overflow}), 0);
        reset = 1'b0;
        cyc(10);
        exp_q.push_back(11'h02B);
        send(8'h2B, 1'b0);
        cyc(40);
        chk("t6_after_rst_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
